// File: rtl/base_decoder_pkg.sv
// base_decoder_pkg: shared defaults and the one-hot decode helper for base_decoder.
package base_decoder_pkg;
    localparam int DEF_IN_W  = 2;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    // Shift form keeps X/Z on idx or en visible in the result instead of masking it.
    function automatic logic [MAX_OUT_W-1:0] onehot_decode(input logic [MAX_IN_W-1:0] idx, input logic en);
        return MAX_OUT_W'(en) << idx;
    endfunction
endpackage

// File: rtl/base_decoder_stats.sv
// base_decoder_stats: single saturating hit counter, cleared by async reset.
module base_decoder_stats #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/base_decoder.sv
// base_decoder: binary-to-one-hot decoder with enable, registered copy and status.
// Define BASE_DECODER_STATS_EN to add per-line saturating hit counters (hit_cnt).
module base_decoder
    import base_decoder_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int CNT_W = DEF_CNT_W,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic [IN_W-1:0]  idx_q,
    output logic             valid_q
`ifdef BASE_DECODER_STATS_EN
    ,
    output logic [OUT_W*CNT_W-1:0] hit_cnt
`endif
);
    if (IN_W < 1 || IN_W > MAX_IN_W || CNT_W < 2 || CNT_W > 16) begin : g_bad_param
        $error("base_decoder: IN_W or CNT_W out of range");
    end

    assign out = OUT_W'(onehot_decode(MAX_IN_W'(in), en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out;
            valid_q <= en;
            if (en) idx_q <= in;
        end
    end

`ifdef BASE_DECODER_STATS_EN
    // out[k] already folds in en, so it is exactly the per-line increment.
    for (genvar k = 0; k < OUT_W; k++) begin : g_stats
        base_decoder_stats #(.CNT_W(CNT_W)) u_stats (
            .clk (clk),
            .rst (rst),
            .inc (out[k]),
            .cnt (hit_cnt[k*CNT_W +: CNT_W])
        );
    end
`endif
endmodule

// File: tb/tb_base_decoder.sv
// tb_base_decoder: randomized and directed checks of base_decoder against a behavioural model.
`timescale 1ns/1ps
module tb_base_decoder;
    localparam int IN_W  = 2;
    localparam int OUT_W = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 0;
    logic rst = 1;
    logic [IN_W-1:0] in = '0;
    logic en = 0;
    logic [OUT_W-1:0] out, out_q;
    logic [IN_W-1:0] idx_q;
    logic valid_q;
    logic [2:0] in3 = '0;
    logic en3 = 0;
    logic [7:0] out3, out_q3;
    logic [2:0] idx_q3;
    logic valid_q3;
`ifdef BASE_DECODER_STATS_EN
    logic [OUT_W*CNT_W-1:0] hit_cnt;
    logic [8*CNT_W-1:0] hit_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    base_decoder #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in(in), .en(en), .out(out), .out_q(out_q),
        .idx_q(idx_q), .valid_q(valid_q)
`ifdef BASE_DECODER_STATS_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    base_decoder #(.IN_W(3), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .rst(rst), .in(in3), .en(en3), .out(out3), .out_q(out_q3),
        .idx_q(idx_q3), .valid_q(valid_q3)
`ifdef BASE_DECODER_STATS_EN
        , .hit_cnt(hit_cnt3)
`endif
    );

    always #5 clk = ~clk;

    logic [OUT_W-1:0] m_out_q = '0;
    int m_idx = 0;
    logic m_valid = 0;
    int m_cnt [OUT_W] = '{default: 0};

    function automatic logic [63:0] ref_out(int idx, logic e);
        return e ? (64'd1 << idx) : 64'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out_q <= '0;
            m_idx   <= 0;
            m_valid <= 0;
            for (int k = 0; k < OUT_W; k++) m_cnt[k] <= 0;
        end else begin
            m_out_q <= OUT_W'(ref_out(int'(in), en));
            m_valid <= en;
            if (en) begin
                m_idx <= int'(in);
                if (m_cnt[int'(in)] < CMAX) m_cnt[int'(in)] <= m_cnt[int'(in)] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out_q"}, 64'(out_q), 64'(m_out_q));
        check({tag, ".idx_q"}, 64'(idx_q), 64'(m_idx));
        check({tag, ".valid_q"}, 64'(valid_q), 64'(m_valid));
`ifdef BASE_DECODER_STATS_EN
        begin
            logic [OUT_W*CNT_W-1:0] e = '0;
            for (int k = 0; k < OUT_W; k++) e[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
            check({tag, ".hit_cnt"}, 64'(hit_cnt), 64'(e));
        end
`endif
    endtask

    initial begin
        #12;
        check("rst.out_q", 64'(out_q), 64'd0);
        check("rst.idx_q", 64'(idx_q), 64'd0);
        check("rst.valid_q", 64'(valid_q), 64'd0);
        rst = 0;
        @(negedge clk);
        in = 3; en = 1;
        #1 check("d1.out", 64'(out), 64'h8);
        @(posedge clk); #1;
        check("d1.out_q", 64'(out_q), 64'h8);
        check("d1.idx_q", 64'(idx_q), 64'd3);
        check("d1.valid_q", 64'(valid_q), 64'd1);
        @(negedge clk);
        in = 1; en = 1;
        #1 check("d2.out", 64'(out), 64'h2);
        @(posedge clk); #1;
        check("d2.idx_q", 64'(idx_q), 64'd1);
        @(negedge clk);
        in = 3; en = 0;
        #1 check("d3.out", 64'(out), 64'h0);
        @(posedge clk); #1;
        check("d3.idx_q", 64'(idx_q), 64'd1);
        check("d3.valid_q", 64'(valid_q), 64'd0);
        check("d3.out_q", 64'(out_q), 64'h0);
        for (int e = 1; e >= 0; e--) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                in = IN_W'(i); en = 1'(e); in3 = 3'(i); en3 = 1'(e);
                #1;
                check("sweep.out", 64'(out), ref_out(i % OUT_W, 1'(e)));
                check("sweep.out3", 64'(out3), ref_out(i, 1'(e)));
            end
        end
        @(negedge clk);
        in = 2; en = 1;
        @(posedge clk); #1;
        check("mid.out_q_pre", 64'(out_q), 64'h4);
        rst = 1;
        #1;
        check("mid.out_q", 64'(out_q), 64'd0);
        check("mid.idx_q", 64'(idx_q), 64'd0);
        check("mid.valid_q", 64'(valid_q), 64'd0);
        check("mid.out", 64'(out), 64'h4);
        in = 1;
        #1 check("mid.out_follow", 64'(out), 64'h2);
        @(negedge clk);
        rst = 0;
        in = 2; en = 1;
        repeat (5) @(posedge clk);
        #1;
`ifdef BASE_DECODER_STATS_EN
        check("sat.hit_cnt", 64'(hit_cnt), 64'h30);
`endif
        check_regs("sat");
        rst = 1;
        #1;
`ifdef BASE_DECODER_STATS_EN
        check("sat.rst_cnt", 64'(hit_cnt), 64'h0);
`endif
        check_regs("sat_rst");
        @(negedge clk);
        rst = 0;
        repeat (400) begin
            @(negedge clk);
            in = IN_W'($urandom_range(0, OUT_W - 1));
            en = ($urandom_range(0, 3) != 0);
            #1 check("rnd.out", 64'(out), ref_out(int'(in), en));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1;
                #1 check_regs("rnd_rst");
                rst = 0;
            end
            @(posedge clk); #1;
            check_regs("rnd");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
